apb3_rr_master_arbiter: RTL and testbench
=========================================

# apb3_rr_master_arbiter

Shares the single APB3 master port of the peripheral bus fabric between NREQ independent requesters, for example the Mi-V core's bus bridge, a camera-frame DMA and a debug/config engine. Each requester issues one transfer at a time over a simple valid/ready request channel and gets back a one-cycle response pulse. The block arbitrates round-robin and sequences the APB3 SETUP/ACCESS phases toward the address-decoding APB3 bus, which fans out to slots 0..2.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- AW, 32: address width (PADDR).
- DW, 32: data width (PWDATA/PRDATA).
- TIMEOUT_CYCLES, 255: ACCESS-phase wait limit. Used only when the timeout feature is compiled in (see Configuration).

Ports:
- Clock and reset: one clock, `PCLK`; reset `PRESET` is synchronous and active-high.
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESET  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester transfer request.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: transfer complete.
- rsp_rdata  out  DW  read data, shared; valid only with rsp_valid.
- rsp_err  out  1  PSLVERR or timeout; valid only with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB3 master controls.
- PADDR  out  AW; PWDATA  out  DW  APB3 master address and data.
- PRDATA  in  DW; PREADY  in  1; PSLVERR  in  1  APB3 master returns.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any req_valid is high, the round-robin winner i is chosen, searching from index (last_grant+1) mod NREQ upward.
  - On that edge: latch addr, wdata and write into PADDR/PWDATA/PWRITE; pulse req_ready[i]; go to SETUP.
  - If no req_valid is high, stay in IDLE.
- **SETUP:** PSEL=1, PENABLE=0. Always go to ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA (reads only; 0 for writes) and PSLVERR; go to IDLE.
  - PREADY=0: stay in ACCESS.
- **Response:** rsp_valid[i], rsp_rdata and rsp_err are registered and appear in the cycle after the ACCESS cycle that sampled PREADY=1.
- **last_grant:** updates to i on acceptance. Reset value is NREQ-1, so requester 0 wins first.
- **Requester obligation:** hold req_valid and its fields stable until req_ready. The requester may deassert the same cycle it sees req_ready. A re-asserted request is treated as new.
- PADDR, PWDATA and PWRITE hold their latched values from SETUP through ACCESS. They keep their last value in IDLE.
- A requester whose req_valid drops before it is granted is simply skipped; nothing is reported back.

## Timing
- **Reset values:** PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- **Minimum latency:**
  - Request sampled at edge 0; SETUP in cycle 1; ACCESS in cycle 2 with PREADY=1; rsp_valid in cycle 3.
  - IDLE is re-entered in cycle 3 and can accept on that edge, so peak throughput is one transfer per 3 cycles.
- Each PREADY=0 cycle in ACCESS adds exactly one cycle of latency.
- **Simultaneous events:** a new request accepted in the same cycle as rsp_valid for the previous transfer is legal and required.
- **Reset mid-transfer:** PRESET=1 in any state forces the reset values at that edge. The in-flight transfer is dropped with no rsp_valid, and last_grant returns to NREQ-1.

## Configuration
- Macro: `APB3_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8..16-bit wait counter clears on entering ACCESS and increments on every ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the FSM returns to IDLE and drops PSEL/PENABLE.
  - The aborted transfer responds with rsp_err=1 and rsp_rdata=0.
- **Not defined:** no counter exists, ACCESS waits indefinitely, and TIMEOUT_CYCLES is ignored.

## Structure
- Package `apb3_arb_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - default AW/DW constants;
  - the timeout counter width.
- Sub-module `rr_select`: a combinational one-hot round-robin picker taking req_valid and last_grant. The last_grant register stays in the parent.

## Test plan
- **Single read:** req 0 reads 0x7000_1004, PRDATA=0xCAFE_0001, PREADY tied 1 -> req_ready[0] at cycle 0, PSEL in cycles 1-2, PENABLE in cycle 2, rsp_valid[0] at cycle 3 with rsp_rdata=0xCAFE_0001 and rsp_err=0.
- **Contention:** req 0 and req 1 both hold valid for 4 transfers -> grants alternate 0,1,0,1 and each transfer takes 3 cycles.
- **Wait states and error:** write with PREADY low 5 cycles and PSLVERR=1 on the completing cycle -> ACCESS lasts 6 cycles, rsp_err=1, rsp_rdata=0.
- **Timeout:** with APB3_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 wait cycles, rsp_err=1, PSEL=0. Without the macro, PSEL stays 1 for 100+ cycles.
- **Reset mid-ACCESS:** PRESET pulsed for 1 cycle during ACCESS -> next cycle all outputs at reset values, no rsp_valid, and the next contended grant goes to requester 0.

Source files
------------

// File: rtl/apb3_arb_pkg.sv
// apb3_arb_pkg
//   Shared definitions for the APB3 round-robin master arbiter:
//   FSM state encoding, default bus widths and the wait-counter width
//   used when the ACCESS timeout (APB3_ARB_TIMEOUT_EN) is compiled in.
package apb3_arb_pkg;

   localparam int ARB_AW   = 32;
   localparam int ARB_DW   = 32;
   // wide enough for any TIMEOUT_CYCLES up to 65535
   localparam int TO_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } arb_state_e;

endpackage

// File: rtl/apb3_rr_master_arbiter_rr_select.sv
// rr_select
//   Combinational one-hot round-robin picker. Searches from
//   (last_grant+1) mod NREQ upward and returns the first active request.
// Ports:
//   req        in  NREQ  active requests
//   last_grant in  GW    index of the previous winner
//   gnt        out NREQ  one-hot winner (all zero when nothing requests)
//   gnt_idx    out GW    binary index of the winner
//   any        out 1     at least one request active
module rr_select
   import apb3_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int GW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [GW-1:0]   gnt_idx,
   output logic            any
);

   int c;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      c       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         // wrap by subtraction so non-power-of-two NREQ works
         c = int'(last_grant) + k;
         if (c >= NREQ) c = c - NREQ;
         if (!any && req[c]) begin
            any     = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = GW'(c);
         end
      end
   end

endmodule

// File: rtl/apb3_rr_master_arbiter.sv
// apb3_rr_master_arbiter
//   Shares one APB3 master port between NREQ requesters. Round-robin
//   arbitration in IDLE, then SETUP/ACCESS sequencing; a registered
//   one-cycle response pulse goes back to the winning requester.
//   Optional macro APB3_ARB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES
//   wait cycles and respond with rsp_err=1, rsp_rdata=0.
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   req_valid/write/addr/wdata  per-requester request channel (packed)
//   req_ready               one-hot accept pulse (cycle in which the
//                           request is sampled)
//   rsp_valid/rdata/err     registered completion pulse, shared data/err
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB3 master outputs (registered)
//   PRDATA/PREADY/PSLVERR   APB3 master returns
module apb3_rr_master_arbiter
   import apb3_arb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int AW             = ARB_AW,
   parameter int DW             = ARB_DW,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [AW-1:0]      PADDR,
   output logic [DW-1:0]      PWDATA,
   input  logic [DW-1:0]      PRDATA,
   input  logic               PREADY,
   input  logic               PSLVERR
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e                state;
   logic [GW-1:0]             last_grant;
   logic [NREQ-1:0]           cur_gnt;
   logic [NREQ-1:0]           sel_gnt;
   logic [GW-1:0]             sel_idx;
   logic                      sel_any;
   logic [NREQ-1:0][AW-1:0]   addr_v;
   logic [NREQ-1:0][DW-1:0]   wdata_v;

   assign addr_v  = req_addr;
   assign wdata_v = req_wdata;

`ifdef APB3_ARB_TIMEOUT_EN
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [TO_CNT_W-1:0] wait_cnt;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   rr_select #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_sel (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (sel_gnt),
      .gnt_idx    (sel_idx),
      .any        (sel_any)
   );

   // Ready is the live grant while IDLE, so the requester sees it in the
   // same cycle the arbiter samples its request.
   assign req_ready = (state == ST_IDLE && !PRESET) ? sel_gnt : '0;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state      <= ST_IDLE;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         cur_gnt    <= '0;
         last_grant <= GW'(NREQ - 1);
`ifdef APB3_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (sel_any) begin
                  PADDR      <= addr_v[sel_idx];
                  PWDATA     <= wdata_v[sel_idx];
                  PWRITE     <= req_write[sel_idx];
                  cur_gnt    <= sel_gnt;
                  last_grant <= sel_idx;
                  PSEL       <= 1'b1;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
`ifdef APB3_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= cur_gnt;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
                  state     <= ST_IDLE;
               end
`ifdef APB3_ARB_TIMEOUT_EN
               // this is the TIMEOUT_CYCLES-th wait cycle: give up
               else if (wait_cnt == TO_LAST) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= cur_gnt;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb3_rr_master_arbiter.sv
// tb_apb3_rr_master_arbiter
//   Directed checks of the main scenarios followed by a randomized run
//   scored against a transaction-level model (round-robin pick from the
//   previous winner, SETUP + (1+waits) ACCESS cycles, response one cycle
//   after completion).
module tb_apb3_rr_master_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
`ifdef APB3_ARB_TIMEOUT_EN
   localparam int TO   = 16;
`else
   localparam int TO   = 255;
`endif

   logic               PCLK = 1'b0;
   logic               PRESET = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_write = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic               PSEL, PENABLE, PWRITE;
   logic [AW-1:0]      PADDR;
   logic [DW-1:0]      PWDATA;
   logic [DW-1:0]      PRDATA = '0;
   logic               PREADY = 1'b1;
   logic               PSLVERR = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 PCLK = ~PCLK;

   apb3_rr_master_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // outputs are observed on the falling edge
   task automatic smp();
      @(negedge PCLK);
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic chk_rst(input string t);
      chk({t, ".psel"},      64'(PSEL),      64'd0);
      chk({t, ".penable"},   64'(PENABLE),   64'd0);
      chk({t, ".pwrite"},    64'(PWRITE),    64'd0);
      chk({t, ".paddr"},     64'(PADDR),     64'd0);
      chk({t, ".pwdata"},    64'(PWDATA),    64'd0);
      chk({t, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({t, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({t, ".rsp_err"},   64'(rsp_err),   64'd0);
   endtask

   // round-robin rule: first active index after the previous winner
   function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int              last, ph, w, g, n_acc;
      bit              busy, done, in_x;
      logic [NREQ-1:0] exp_r, exp_v, m_gnt, acc_prev;
      logic [AW-1:0]   m_addr;
      logic [DW-1:0]   m_wd, m_rd;
      logic            m_wr, m_err;

      // ---------------- reset values ----------------
      req_valid = 3'b001;
      tick(); tick(); smp();
      chk_rst("rst");
      chk("rst.ready", 64'(req_ready), 64'd0);
      tick(); PRESET = 1'b0; req_valid = '0;
      smp();
      chk("idle.ready", 64'(req_ready), 64'd0);
      chk("idle.psel", 64'(PSEL), 64'd0);

      // ---------------- single read ----------------
      tick(); set_req(0, 1'b0, 32'h7000_1004, 32'h1111_2222);
      PRDATA = 32'hCAFE_0001; PREADY = 1'b1; PSLVERR = 1'b0;
      smp(); chk("rd.ready", 64'(req_ready), 64'h1);
      tick(); req_valid = '0;
      smp();
      chk("rd.setup_psel", 64'(PSEL), 64'd1);
      chk("rd.setup_pen", 64'(PENABLE), 64'd0);
      chk("rd.paddr", 64'(PADDR), 64'h7000_1004);
      chk("rd.pwrite", 64'(PWRITE), 64'd0);
      tick(); smp();
      chk("rd.acc_psel", 64'(PSEL), 64'd1);
      chk("rd.acc_pen", 64'(PENABLE), 64'd1);
      chk("rd.acc_rsp", 64'(rsp_valid), 64'd0);
      tick(); smp();
      chk("rd.rsp_valid", 64'(rsp_valid), 64'h1);
      chk("rd.rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
      chk("rd.rsp_err", 64'(rsp_err), 64'd0);
      chk("rd.psel_off", 64'(PSEL), 64'd0);

      // ---------------- write, 5 wait states, PSLVERR ----------------
      tick(); set_req(1, 1'b1, 32'h7000_2008, 32'hDEAD_BEEF); PREADY = 1'b0;
      smp(); chk("wr.ready", 64'(req_ready), 64'h2);
      tick(); req_valid = '0;
      smp();
      chk("wr.setup_pen", 64'(PENABLE), 64'd0);
      chk("wr.pwrite", 64'(PWRITE), 64'd1);
      chk("wr.pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
      chk("wr.paddr", 64'(PADDR), 64'h7000_2008);
      for (int k = 1; k <= 6; k++) begin
         tick(); PREADY = (k == 6); PSLVERR = (k == 6); PRDATA = 32'h5555_AAAA;
         smp();
         chk("wr.acc_psel", 64'(PSEL), 64'd1);
         chk("wr.acc_pen", 64'(PENABLE), 64'd1);
         chk("wr.acc_norsp", 64'(rsp_valid), 64'd0);
      end
      tick(); PREADY = 1'b0; PSLVERR = 1'b0;
      smp();
      chk("wr.rsp_valid", 64'(rsp_valid), 64'h2);
      chk("wr.rsp_err", 64'(rsp_err), 64'd1);
      chk("wr.rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("wr.psel_off", 64'(PSEL), 64'd0);

      // ---------------- reset during ACCESS ----------------
      tick(); set_req(0, 1'b0, 32'h7000_0010, 32'h0);
      smp(); chk("mid.ready", 64'(req_ready), 64'h1);
      tick(); req_valid = '0;
      tick(); smp(); chk("mid.in_access", 64'(PENABLE), 64'd1);
      tick(); PRESET = 1'b1;
      tick(); PRESET = 1'b0; req_write = '0; req_valid = 3'b011;
      PREADY = 1'b1; PRDATA = 32'h1234_5678;
      smp();
      chk_rst("mid");
      chk("mid.first_grant", 64'(req_ready), 64'h1);

      // ---------------- contention between 0 and 1 ----------------
      for (int j = 1; j <= 12; j++) begin
         tick();
         if (j == 10) req_valid = '0;
         smp();
         exp_r = (j % 3 == 0 && j <= 9) ? (((j / 3) % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
         exp_v = (j % 3 == 0) ? (((j / 3) % 2 == 1) ? 3'b001 : 3'b010) : 3'b000;
         chk("cont.ready", 64'(req_ready), 64'(exp_r));
         chk("cont.rsp_valid", 64'(rsp_valid), 64'(exp_v));
         if (j % 3 == 0) chk("cont.rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
      end

      // ---------------- randomized run vs. transaction model ----------------
      last = 1; busy = 0; ph = 0; w = 0; acc_prev = '0;
      m_gnt = '0; m_addr = '0; m_wd = '0; m_wr = 1'b0; m_rd = '0; m_err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (busy) ph++;
         for (int i = 0; i < NREQ; i++) begin
            if (c >= 2960) begin
               req_valid[i] = 1'b0;
            end else if (acc_prev[i] || !req_valid[i]) begin
               req_valid[i]          = ($urandom_range(0, 2) != 0);
               req_write[i]          = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW]  = $urandom;
               req_wdata[i*DW +: DW] = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;   // withdrawn before grant
            end
         end
         PRDATA  = $urandom;
         PSLVERR = 1'($urandom_range(0, 1));
         if (busy && ph >= 2 && ph <= 2 + w) PREADY = (ph == 2 + w);
         else PREADY = 1'($urandom_range(0, 1));
         if (busy && ph == 2 + w) begin
            m_rd  = m_wr ? '0 : PRDATA;
            m_err = PSLVERR;
         end
         smp();
         in_x = busy && ph >= 1 && ph <= 2 + w;
         chk("rnd.psel", 64'(PSEL), 64'(in_x));
         chk("rnd.penable", 64'(PENABLE), 64'(busy && ph >= 2 && ph <= 2 + w));
         if (in_x) begin
            chk("rnd.paddr", 64'(PADDR), 64'(m_addr));
            chk("rnd.pwdata", 64'(PWDATA), 64'(m_wd));
            chk("rnd.pwrite", 64'(PWRITE), 64'(m_wr));
         end
         if (busy && ph == 3 + w) begin
            chk("rnd.rsp_valid", 64'(rsp_valid), 64'(m_gnt));
            chk("rnd.rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
            chk("rnd.rsp_err", 64'(rsp_err), 64'(m_err));
            busy = 0;
         end else begin
            chk("rnd.no_rsp", 64'(rsp_valid), 64'd0);
         end
         exp_r = '0;
         if (!busy) begin
            g = rr_pick(last, req_valid);
            if (g >= 0) begin
               exp_r[g] = 1'b1;
               busy   = 1; ph = 0; w = $urandom_range(0, 4);
               m_gnt  = exp_r;
               m_addr = req_addr[g*AW +: AW];
               m_wd   = req_wdata[g*DW +: DW];
               m_wr   = req_write[g];
               last   = g;
            end
         end
         chk("rnd.ready", 64'(req_ready), 64'(exp_r));
         acc_prev = exp_r;
      end

      // ---------------- ACCESS that never completes ----------------
      tick(); set_req(2, 1'b0, 32'h7000_3000, 32'h0);
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_0000;
      smp(); chk("to.ready", 64'(req_ready), 64'h4);
      tick(); req_valid = '0;
      n_acc = 0; done = 0;
`ifdef APB3_ARB_TIMEOUT_EN
      for (int k = 0; k < 200 && !done; k++) begin
         tick(); smp();
         if (PSEL && PENABLE) n_acc++;
         else done = 1;
      end
      chk("to.aborted", 64'(done), 64'd1);
      chk("to.wait_cycles", 64'(n_acc), 64'd16);
      chk("to.psel", 64'(PSEL), 64'd0);
      chk("to.rsp_valid", 64'(rsp_valid), 64'h4);
      chk("to.rsp_err", 64'(rsp_err), 64'd1);
      chk("to.rsp_rdata", 64'(rsp_rdata), 64'd0);
`else
      for (int k = 0; k < 120; k++) begin
         tick(); smp();
         if (PSEL && PENABLE && rsp_valid == '0) n_acc++;
      end
      chk("noto.held_cycles", 64'(n_acc), 64'd120);
      tick(); PRESET = 1'b1;
      tick(); PRESET = 1'b0;
      smp();
      chk_rst("noto.rst");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
